// File: rtl/hilo_ctrl_pkg.sv
// Shared HILO constants: operation encodings used by the decoder and hilo_ctrl,
// plus the sequencer state type and small op-classification helpers.
package hilo_ctrl_pkg;

  localparam logic [4:0] HILOType_mult  = 5'd0;
  localparam logic [4:0] HILOType_multu = 5'd1;
  localparam logic [4:0] HILOType_div   = 5'd2;
  localparam logic [4:0] HILOType_divu  = 5'd3;
  localparam logic [4:0] HILOType_mfhi  = 5'd4;
  localparam logic [4:0] HILOType_mflo  = 5'd5;
  localparam logic [4:0] HILOType_mthi  = 5'd6;
  localparam logic [4:0] HILOType_mtlo  = 5'd7;
  localparam logic [4:0] HILOType_error = 5'd31;

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hilo_state_t;

  function automatic logic is_md_op(input logic [4:0] op);
    return (op == HILOType_mult) || (op == HILOType_multu) ||
           (op == HILOType_div)  || (op == HILOType_divu);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == HILOType_div) || (op == HILOType_divu);
  endfunction

endpackage

// File: rtl/hilo_ctrl_md_core.sv
// Combinational multiply/divide datapath: (op, a, b) -> {hi_res, lo_res, div0}.
// Keeps all signed/unsigned arithmetic out of the sequencer.
module md_core
  import hilo_ctrl_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div0
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe;
  logic               ovf;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic        [31:0] uq;
  logic        [31:0] ur;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Dividing by 1 instead of -1 in the overflow case yields exactly the
  // required quotient 0x80000000 and remainder 0, and avoids a zero divisor.
  assign ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_safe = ((b == 32'd0) || ovf) ? 32'd1 : b;

  assign sq = $signed(a) / $signed(b_safe);
  assign sr = $signed(a) % $signed(b_safe);
  assign uq = a / b_safe;
  assign ur = a % b_safe;

  assign div0 = is_div_op(op) && (b == 32'd0);

  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      HILOType_mult: begin
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
      end
      HILOType_multu: begin
        hi_res = prod_u[63:32];
        lo_res = prod_u[31:0];
      end
      HILOType_div: begin
        hi_res = sr;
        lo_res = sq;
      end
      HILOType_divu: begin
        hi_res = ur;
        lo_res = uq;
      end
      default: begin
        hi_res = 32'd0;
        lo_res = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/hilo_ctrl.sv
// E-stage multiply/divide sequencer and HI/LO register file. Models mult/div
// latency with a countdown FSM and raises the D-stage stall while occupied.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_Req,
  input  logic [4:0]  E_HILOType,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [4:0]  D_HILOType,
  output logic        Start,
  output logic        Busy,
  output logic        HILO_Stall,
  output logic [31:0] HILO_Out
);

  hilo_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      hi, hi_n;
  logic [31:0]      lo, lo_n;
  logic [31:0]      hi_pend, hi_pend_n;
  logic [31:0]      lo_pend, lo_pend_n;

  logic [31:0]      hi_res;
  logic [31:0]      lo_res;
  logic             div0;

  md_core u_md_core (
    .op     (E_HILOType),
    .a      (E_A),
    .b      (E_B),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .div0   (div0)
  );

  assign Start      = E_Req && is_md_op(E_HILOType) && (state == IDLE);
  assign Busy       = (state == BUSY);
  assign HILO_Stall = (D_HILOType != HILOType_error) && (Start || Busy);
  assign HILO_Out   = (E_HILOType == HILOType_mfhi) ? hi : lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      hi_pend <= 32'd0;
      lo_pend <= 32'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi      <= hi_n;
      lo      <= lo_n;
      hi_pend <= hi_pend_n;
      lo_pend <= lo_pend_n;
    end
  end

  // A zero divisor latches the current HI/LO as the pending result, so the
  // normal commit leaves them unchanged; HI/LO cannot move while BUSY.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi;
    lo_n      = lo;
    hi_pend_n = hi_pend;
    lo_pend_n = lo_pend;
    case (state)
      IDLE: begin
        if (Start) begin
          state_n   = BUSY;
          cnt_n     = is_div_op(E_HILOType) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          hi_pend_n = div0 ? hi : hi_res;
          lo_pend_n = div0 ? lo : lo_res;
        end else if (E_Req && (E_HILOType == HILOType_mthi)) begin
          hi_n = E_A;
        end else if (E_Req && (E_HILOType == HILOType_mtlo)) begin
          lo_n = E_A;
        end
      end
      BUSY: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          hi_n    = hi_pend;
          lo_n    = lo_pend;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: expected HI/LO pairs are queued at issue
// and popped when the result is read back through mfhi/mflo.
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        eReq;
  logic [4:0]  eType;
  logic [31:0] eA;
  logic [31:0] eB;
  logic [4:0]  dType;
  logic        start;
  logic        busy;
  logic        stall;
  logic [31:0] hiloOut;

  int compareCount = 0;
  int failCount    = 0;
  logic [63:0] expQ[$];

  hilo_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .E_Req      (eReq),
    .E_HILOType (eType),
    .E_A        (eA),
    .E_B        (eB),
    .D_HILOType (dType),
    .Start      (start),
    .Busy       (busy),
    .HILO_Stall (stall),
    .HILO_Out   (hiloOut)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one mult/div in E with a dependent mflo in D, then count BUSY and
  // stall cycles. Optionally slip an mthi into E on the first BUSY cycle.
  task automatic applyStimulus(input string tag, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int cycles,
                               input logic [31:0] expHi, input logic [31:0] expLo,
                               input bit intrude);
    int busyCount;
    int stallCount;
    busyCount = 0;
    @(negedge clk);
    eReq = 1'b1; eType = op; eA = a; eB = b; dType = HILOType_mflo;
    #1;
    checkOutput({tag, "_start"}, {31'd0, start}, 32'd1);
    stallCount = int'(stall);
    expQ.push_back({expHi, expLo});
    @(negedge clk);
    eReq = 1'b0; eType = HILOType_error;
    #1;
    while (busy && busyCount < 40) begin
      busyCount++;
      stallCount += int'(stall);
      if (intrude && busyCount == 1) begin
        eReq = 1'b1; eType = HILOType_mthi; eA = 32'hDEAD_BEEF;
      end else begin
        eReq = 1'b0; eType = HILOType_error;
      end
      @(negedge clk);
      #1;
    end
    eReq = 1'b0; eType = HILOType_error;
    checkOutput({tag, "_busycycles"}, 32'(busyCount), 32'(cycles));
    checkOutput({tag, "_stallcycles"}, 32'(stallCount), 32'(cycles + 1));
    #1;
    checkOutput({tag, "_stallafter"}, {31'd0, stall}, 32'd0);
  endtask

  // Pop the oldest expected result and read it back via mfhi then mflo.
  task automatic readBack(input string tag);
    logic [63:0] exp;
    if (expQ.size() == 0) begin
      checkOutput({tag, "_queue"}, 32'd0, 32'd1);
      return;
    end
    exp = expQ.pop_front();
    @(negedge clk);
    eReq = 1'b1; eType = HILOType_mfhi; dType = HILOType_error;
    #1;
    checkOutput({tag, "_hi"}, hiloOut, exp[63:32]);
    @(negedge clk);
    eType = HILOType_mflo;
    #1;
    checkOutput({tag, "_lo"}, hiloOut, exp[31:0]);
    @(negedge clk);
    eReq = 1'b0; eType = HILOType_error;
  endtask

  task automatic moveTo(input logic [4:0] op, input logic [31:0] value);
    @(negedge clk);
    eReq = 1'b1; eType = op; eA = value; dType = HILOType_error;
    #1;
    checkOutput("mt_nostart", {31'd0, start}, 32'd0);
    @(negedge clk);
    eType = (op == HILOType_mthi) ? HILOType_mfhi : HILOType_mflo;
    #1;
    checkOutput("mt_visible", hiloOut, value);
    eReq = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] rp;
    int hold;
    reset = 1'b1; eReq = 1'b0; eType = HILOType_error; eA = '0; eB = '0;
    dType = HILOType_error;
    #12;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_start", {31'd0, start}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_out", hiloOut, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("mult", HILOType_mult, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    readBack("mult");
    applyStimulus("multu", HILOType_multu, 32'hFFFF_FFFF, 32'd2, 5, 32'd1, 32'hFFFF_FFFE, 1'b0);
    readBack("multu");
    applyStimulus("div", HILOType_div, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    readBack("div");
    applyStimulus("divneg", HILOType_div, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, 1'b0);
    readBack("divneg");
    applyStimulus("divovf", HILOType_div, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0);
    readBack("divovf");

    moveTo(HILOType_mthi, 32'h0000_1234);
    moveTo(HILOType_mtlo, 32'h0000_5678);
    applyStimulus("divu0", HILOType_divu, 32'd99, 32'd0, 10, 32'h0000_1234, 32'h0000_5678, 1'b0);
    readBack("divu0");

    applyStimulus("intrude", HILOType_multu, 32'd6, 32'd7, 5, 32'd0, 32'd42, 1'b1);
    readBack("intrude");

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 100000);
      rp = {32'd0, ra} * {32'd0, rb};
      applyStimulus("rmultu", HILOType_multu, ra, rb, 5, rp[63:32], rp[31:0], 1'b0);
      readBack("rmultu");
      applyStimulus("rdivu", HILOType_divu, ra, rb, 10, ra % rb, ra / rb, 1'b0);
      readBack("rdivu");
    end

    // HI/LO are nonzero here, so the reset check below is meaningful.
    @(negedge clk);
    eReq = 1'b1; eType = HILOType_div; eA = 32'd100; eB = 32'd3; dType = HILOType_mflo;
    @(negedge clk);
    eReq = 1'b0; eType = HILOType_mfhi;
    hold = 0;
    #1;
    while (busy && hold < 2) begin
      hold++;
      @(negedge clk);
      #1;
    end
    checkOutput("rstmid_wasbusy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstmid_stall", {31'd0, stall}, 32'd0);
    checkOutput("rstmid_hi", hiloOut, 32'd0);
    eType = HILOType_mflo;
    #1;
    checkOutput("rstmid_lo", hiloOut, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dType = HILOType_error;
    repeat (12) @(negedge clk);
    eType = HILOType_mfhi;
    #1;
    checkOutput("rstmid_nocommit", hiloOut, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Multiply/divide sequencer and HI/LO register file for the five-stage pipeline. It sits in the E stage beside the ALU. It accepts the `HILOType` operation code produced by the decoder, models multi-cycle `mult`/`multu`/`div`/`divu` latency with a countdown FSM, and commits results to HI/LO. It also executes `mthi`/`mtlo`, serves `mfhi`/`mflo` reads, and raises the stall request the hazard unit uses to hold D while the unit is occupied.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `E_Req`  in  1: a valid (not flushed) instruction occupies E.
- `E_HILOType`  in  5: operation of the E instruction, `HILOType_*` encoding.
- `E_A`  in  32: forwarded rs value.
- `E_B`  in  32: forwarded rt value.
- `D_HILOType`  in  5: operation of the D instruction.
- `Start`  out  1: combinational; `E_Req` and E op is mult/multu/div/divu and FSM is IDLE.
- `Busy`  out  1: registered; high while the FSM is in BUSY.
- `HILO_Stall`  out  1: combinational; D op is not `HILOType_error` and (`Start` or `Busy`).
- `HILO_Out`  out  32: combinational; HI when E op is `mfhi`, LO otherwise.

## Operation
- FSM states are IDLE and BUSY. State registers: `state`, 4-bit `cnt`, `hi`, `lo`, `hi_pend`, `lo_pend`.
- IDLE to BUSY happens on `Start`. At that edge:
  - `cnt` loads `MULT_CYCLES` or `DIV_CYCLES`.
  - `hi_pend`/`lo_pend` latch the result computed from `E_A`/`E_B`.
- In BUSY, `cnt` decrements every cycle. On the edge where `cnt==1`, `hi`/`lo` take `hi_pend`/`lo_pend` and the FSM returns to IDLE.
- Result rules:
  - `mult`: signed 32×32 to 64. `multu`: unsigned 32×32 to 64. HI = [63:32], LO = [31:0].
  - `div`: LO = quotient truncated toward zero, HI = remainder with the dividend's sign. `0x80000000 / 0xFFFFFFFF` gives LO=`0x80000000`, HI=0.
  - `divu`: unsigned quotient and remainder.
  - Divisor 0 (div/divu): the FSM still goes BUSY for `DIV_CYCLES`, and HI/LO keep their prior values at commit.
- `mthi`/`mtlo`: when `E_Req` is high and the FSM is IDLE, `hi`/`lo` take `E_A` at the edge. This is single-cycle, with no BUSY.
- A mult/div/mthi/mtlo arriving in E while BUSY is prevented by `HILO_Stall`. If one arrives anyway, it is ignored and HI/LO are unchanged.
- `mfhi`/`mflo` read the committed `hi`/`lo` only. The stall guarantees no pending result is bypassed.
- `E_Req` low: no state change. The E-stage instruction is treated as a bubble.

## Timing
- Reset values: `state`=IDLE, `cnt`=0, `hi`=`lo`=0, `hi_pend`=`lo_pend`=0. Outputs: `Busy`=0, `Start`=0 (with `E_Req`=0), `HILO_Stall`=0, `HILO_Out`=0.
- A mult issued in E at cycle t gives:
  - `Start`=1 at t.
  - `Busy`=1 for cycles t+1 … t+`MULT_CYCLES`.
  - HI/LO visible from t+`MULT_CYCLES`+1.
  - Div timing is identical with `DIV_CYCLES`.
- `HILO_Stall` covers cycles t … t+N. A dependent `mfhi` in D issues into E at t+N+1 and reads the new value.
- `mthi` at t: the new HI is visible to `mfhi` in E at t+1.
- `reset` asserted mid-BUSY clears everything immediately. The pending result is lost and HI/LO read 0.
- `cnt` never wraps. It only decrements in BUSY, where it is ≥1.

## Structure
- The shared constants file holds the `HILOType_*` encodings: mult=0, multu=1, div=2, divu=3, mfhi=4, mflo=5, mthi=6, mtlo=7, error=31.
- The decoder and `hilo_ctrl` include the same file.
- One sub-module, `md_core`, is purely combinational: (op, A, B) to {hi_res, lo_res, div0}. It isolates the signed/unsigned arithmetic from the FSM.

## Test plan
- Reset, then `mult` with A=`0xFFFFFFFE` (−2), B=3. Required: `Busy` high for exactly 5 cycles, then HI=`0xFFFFFFFF`, LO=`0xFFFFFFFA`.
- `multu` with A=`0xFFFFFFFF`, B=2. Required: HI=1, LO=`0xFFFFFFFE`.
- `div` with A=`0xFFFFFFF9` (−7), B=2. Required: `Busy` for 10 cycles, LO=`0xFFFFFFFD`, HI=`0xFFFFFFFF`.
- `divu` by 0 after `mthi 0x1234` / `mtlo 0x5678`. Required: `Busy` for 10 cycles, HI/LO remain `0x1234`/`0x5678`.
- `mult` in E with `mflo` in D. Required: `HILO_Stall`=1 for 6 cycles (t … t+5). `mflo` then returns the product.
- `reset` pulsed on the 3rd BUSY cycle of a `div`. Required: `Busy`=0, HI=LO=0, `HILO_Stall`=0 immediately.
